frame_serializer: RTL
=====================

# frame_serializer

Transmit-path stage directly downstream of the sorter. Accepts a complete assembled frame (preamble, start character, data, indices, end character) as one wide word on the sorter's one-cycle `done` pulse. Shifts it out one bit at a time at a fixed bit rate, optionally differentially encoded, as the phase-select bit for the BPSK modulator. A one-frame holding slot absorbs a new frame arriving while one is still on the air.

## Interface
- `FRAME_WIDTH`, default `SORTING_WIDTH + PREAMBLE_LENGTH + PACKET_WIDTH_BITS`: frame width in bits.
- `SAMPLES_PER_BIT`, default 8: clock cycles per transmitted bit, minimum 1.
- `GAP_BITS`, default 4: idle bit periods between consecutive frames, 0 allowed.
- `DIFF_ENCODE`, default 1'b1: 1 = differential encoding, 0 = raw bit.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_in`  in  FRAME_WIDTH  assembled frame; bit 0 is the first preamble bit.
- `load`  in  1  one-cycle pulse; samples `frame_in` (driven from the sorter's `done`).
- `tx_phase`  out  1  modulator phase select (0 = 0°, 1 = 180°).
- `tx_active`  out  1  high while a frame's bits are being driven.
- `bit_strobe`  out  1  high on the first cycle of every transmitted bit.
- `frame_done`  out  1  one-cycle pulse after a frame's last bit period.
- `busy`  out  1  high whenever the state is not IDLE or the pending slot is full.
- `overrun`  out  1  one-cycle pulse when a `load` is dropped.

## Operation
- Storage:
  - shift register `shreg` (FRAME_WIDTH).
  - pending register plus `pend_valid`.
  - sample counter, width `$clog2(SAMPLES_PER_BIT)`, minimum 1 bit.
  - bit counter, width `$clog2(FRAME_WIDTH+1)`.
  - gap counter.
  - phase register `ph`.
- Transmission order is LSB first: preamble, start char, data, indices, end char.
- States:
  - IDLE -> SHIFT: on `load` (frame goes straight into `shreg`), or when `pend_valid` is set (pending moves to `shreg` and `pend_valid` clears).
  - SHIFT -> GAP: after the last sample of bit FRAME_WIDTH-1, with `GAP_BITS` > 0.
  - SHIFT -> IDLE: same point, with `GAP_BITS` = 0.
  - GAP -> IDLE: after `GAP_BITS`·`SAMPLES_PER_BIT` cycles.
- In IDLE, pending has priority over a simultaneous `load`. The `load` frame then goes into the pending slot, which was freed the same cycle.
- `load` while in SHIFT or GAP:
  - pending empty: store in pending.
  - pending full: drop the new frame, pulse `overrun`; pending is unchanged.
  - the slot is consumed in the same cycle: accept into the slot, no overrun.
- Per-bit behaviour:
  - At each bit start, `b = shreg[0]`.
  - `DIFF_ENCODE`=1: `ph <= ph ^ b`. `DIFF_ENCODE`=0: `ph <= b`.
  - `shreg` shifts right at bit end.
- `ph` clears to 0 on every SHIFT entry, so each frame starts from reference phase 0.
- `tx_phase` = `ph` during SHIFT, 0 otherwise.
- Counters wrap only via explicit reload at state entry. No modulo arithmetic on the frame index.

## Timing
- `load` sampled at edge N in IDLE:
  - `tx_active`=1, `bit_strobe`=1 and bit 0's phase on `tx_phase` from cycle N+1.
  - each bit is held exactly `SAMPLES_PER_BIT` cycles.
  - the last bit occupies cycles N+1+(FRAME_WIDTH-1)·S through N+FRAME_WIDTH·S, where S = `SAMPLES_PER_BIT`.
- `frame_done` pulses in cycle N+1+FRAME_WIDTH·S, the same cycle `tx_active` falls.
- Back-to-back pending frame:
  - next `tx_active` rise at (`frame_done` cycle) + `GAP_BITS`·S + 1.
  - with `GAP_BITS`=0, it rises in the cycle after `frame_done`, i.e. a one-cycle IDLE.
- `SAMPLES_PER_BIT`=1: `bit_strobe` is high every SHIFT cycle.
- Reset (asynchronous assert, any state, including mid-frame):
  - state IDLE, `pend_valid`=0, all counters 0, `ph`=0.
  - all outputs 0.
  - the in-flight frame is abandoned and `frame_done` is not issued.
  - `load` during reset is ignored.
- `busy` is combinational from state and `pend_valid`. All other outputs are registered.

## Structure
- Package `bpsk_tx_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT, GAP}.
  - `localparam FRAME_WIDTH_DEFAULT`, derived from the core, network and preamble parameter headers.
- Sub-module `bit_timer`:
  - parameter `SAMPLES_PER_BIT`; ports `clk`, `reset`, `run`.
  - outputs `bit_start`, `bit_end`.
  - counter restarts whenever `run` rises; used for both SHIFT and GAP timing.
- Top level holds the FSM, shift/pending registers and encoder.

## Test plan
- `FRAME_WIDTH`=8, S=4, `DIFF_ENCODE`=0, `load` 8'hA5 -> `tx_phase` sequence 1,0,1,0,0,1,0,1, each 4 cycles; `frame_done` exactly 33 cycles after the `load` edge.
- Same frame, `DIFF_ENCODE`=1 -> `tx_phase` 1,1,0,0,0,1,1,0. Second frame also starts from phase 0.
- `GAP_BITS`=2; second `load` (8'h0F) mid-frame -> pending accepted, no `overrun`; second `tx_active` rises 9 cycles after the first `frame_done`.
- Third `load` while pending full -> one-cycle `overrun`; only the first two frames are transmitted.
- `load` in the exact cycle pending is consumed -> accepted, no `overrun`; three frames go out in order.
- `reset` low at bit 3 of a frame -> all outputs 0 asynchronously, no `frame_done`; after release a fresh `load` transmits correctly from bit 0.

Source files
------------

// File: rtl/bpsk_tx_pkg.sv
// Shared definitions for the BPSK transmit path: frame geometry and the
// serializer state type.
package bpsk_tx_pkg;

   // Frame geometry mirrored from the core, network and preamble headers.
   localparam int unsigned PREAMBLE_LENGTH     = 16;
   localparam int unsigned SORTING_WIDTH       = 64;
   localparam int unsigned PACKET_WIDTH_BITS   = 16;
   localparam int unsigned FRAME_WIDTH_DEFAULT = SORTING_WIDTH + PREAMBLE_LENGTH + PACKET_WIDTH_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts SAMPLES_PER_BIT cycles per bit while run is high and
// restarts from zero whenever run rises.
module bit_timer #(
   parameter int unsigned SAMPLES_PER_BIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bit_start,
   output logic bit_end
);

   localparam int unsigned CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (run && (cnt_q != LAST_SAMPLE)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_start = run && (cnt_q == '0);
   assign bit_end   = run && (cnt_q == LAST_SAMPLE);

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: shifts a sorter-assembled frame out LSB first as the BPSK
// phase-select bit, with a one-frame holding slot for back-to-back frames.
module frame_serializer
   import bpsk_tx_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH     = FRAME_WIDTH_DEFAULT,
   parameter int unsigned SAMPLES_PER_BIT = 8,
   parameter int unsigned GAP_BITS        = 4,
   parameter logic        DIFF_ENCODE     = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [FRAME_WIDTH-1:0] frame_in,
   input  logic                   load,
   output logic                   tx_phase,
   output logic                   tx_active,
   output logic                   bit_strobe,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   overrun
);

   localparam int unsigned BCNT_W = $clog2(FRAME_WIDTH + 1);
   localparam int unsigned GCNT_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_WIDTH - 1);
   localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   ser_state_t             state_q, state_d;
   logic [FRAME_WIDTH-1:0] shreg_q, shreg_d;
   logic [FRAME_WIDTH-1:0] pend_q, pend_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [GCNT_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic                   ph_q, ph_d;
   logic                   tx_phase_q, tx_phase_d;
   logic                   tx_active_q, tx_active_d;
   logic                   bit_strobe_q, bit_strobe_d;
   logic                   frame_done_q, frame_done_d;
   logic                   overrun_q, overrun_d;

   logic                   start, load_taken;
   logic [FRAME_WIDTH-1:0] start_frame;
   logic                   bit_end, unused_bit_start;

   bit_timer #(
      .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .run      (state_q != IDLE),
      .bit_start(unused_bit_start),
      .bit_end  (bit_end)
   );

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      ph_d         = ph_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      start        = 1'b0;
      start_frame  = '0;
      load_taken   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_valid_q) begin
               start        = 1'b1;
               start_frame  = pend_q;
               pend_valid_d = 1'b0;
            end else if (load) begin
               start       = 1'b1;
               start_frame = frame_in;
               load_taken  = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  frame_done_d = 1'b1;
                  gap_cnt_d    = '0;
                  state_d      = (GAP_BITS > 0) ? GAP : IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = shreg_q >> 1;
                  ph_d      = DIFF_ENCODE ? (ph_q ^ shreg_d[0]) : shreg_d[0];
               end
            end
         end
         GAP: begin
            if (bit_end) begin
               if (gap_cnt_q == LAST_GAP) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Phase restarts from reference 0, so bit 0's phase is the bit itself in both encodings.
      if (start) begin
         state_d   = SHIFT;
         shreg_d   = start_frame;
         bit_cnt_d = '0;
         ph_d      = start_frame[0];
      end

      // A slot freed by this cycle's IDLE hand-off is already visible in pend_valid_d.
      if (load && !load_taken) begin
         if (!pend_valid_d) begin
            pend_d       = frame_in;
            pend_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      tx_active_d  = (state_d == SHIFT);
      tx_phase_d   = (state_d == SHIFT) && ph_d;
      bit_strobe_d = (state_d == SHIFT) && ((state_q != SHIFT) || bit_end);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         ph_q         <= 1'b0;
         tx_phase_q   <= 1'b0;
         tx_active_q  <= 1'b0;
         bit_strobe_q <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         ph_q         <= ph_d;
         tx_phase_q   <= tx_phase_d;
         tx_active_q  <= tx_active_d;
         bit_strobe_q <= bit_strobe_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign tx_phase   = tx_phase_q;
   assign tx_active  = tx_active_q;
   assign bit_strobe = bit_strobe_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != IDLE) || pend_valid_q;

endmodule
